// File: rtl/chipper_pkg.sv
// rtl/chipper_pkg.sv - flit format, direction codes and blank flit shared by ejector and injector
// Flit layout: [9] golden, [8:6] dir, [5:0] destination ([5:3] row, [2:0] col).
package chipper_pkg;

    localparam int FLIT_W     = 10;
    localparam int ADDR_W     = 6;
    localparam int GOLDEN_BIT = 9;
    localparam int DIR_HI     = 8;
    localparam int DIR_LO     = 6;
    localparam int DEST_HI    = 5;
    localparam int DEST_LO    = 0;

    typedef enum logic [2:0] {
        DIR_E     = 3'b000,
        DIR_W     = 3'b001,
        DIR_N     = 3'b010,
        DIR_S     = 3'b011,
        DIR_LOCAL = 3'b100,
        DIR_BLANK = 3'b111
    } dir_e;

    localparam logic [FLIT_W-1:0] BLANK_FLIT = 10'b0_111_000000;

    // A slot is empty when its dir field carries the blank code.
    function automatic logic is_blank(input logic [FLIT_W-1:0] f);
        return f[DIR_HI:DIR_LO] == DIR_BLANK;
    endfunction

endpackage

// File: rtl/eject_fifo.sv
// rtl/eject_fifo.sv - small ejection FIFO with wrapping pointers and occupancy count
// Ports: clk, rst (async active-high); push/din/full; pop/dout/empty; count.
// A push while full or a pop while empty is ignored. dout shows EMPTY_VAL when empty.
module eject_fifo #(
    parameter int               WIDTH     = 10,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    // Fullness and emptiness come from the registered count, so a pop
    // never makes room for a push in the same cycle.
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? EMPTY_VAL : mem_q[rd_ptr_q];

    always_comb begin
        push_en  = push && !full;
        pop_en   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q + CW'(push_en) - CW'(pop_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/ejector.sv
// rtl/ejector.sv - ejection stage: pulls at most one local flit per cycle into a FIFO
// Ports: clk, rst (async active-high); northad/southad/eastad/westad inbound flits;
// localad node address; nad/sad/ead/wad registered pass-through (ejected slot blank);
// ejd/ej_valid/ej_ready local delivery; ej_count_o/ej_block_o only under EJECTOR_STATS_EN.
module ejector
    import chipper_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] northad,
    input  logic [FLIT_W-1:0] southad,
    input  logic [FLIT_W-1:0] eastad,
    input  logic [FLIT_W-1:0] westad,
    input  logic [ADDR_W-1:0] localad,
    output logic [FLIT_W-1:0] nad,
    output logic [FLIT_W-1:0] sad,
    output logic [FLIT_W-1:0] ead,
    output logic [FLIT_W-1:0] wad,
    output logic [FLIT_W-1:0] ejd,
    input  logic              ej_ready,
    output logic              ej_valid
`ifdef EJECTOR_STATS_EN
    ,
    output logic [15:0]       ej_count_o,
    output logic [15:0]       ej_block_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Slot index order doubles as the tie-break order: 0=N, 1=S, 2=E, 3=W.
    logic [3:0][FLIT_W-1:0] flit_in;
    logic [3:0][FLIT_W-1:0] out_q, out_d;
    logic [3:0]             cand, gold_cand, pool;
    logic [1:0]             win_idx;
    logic                   win_valid, do_eject;
    logic [FLIT_W-1:0]      push_data;
    logic                   fifo_full, fifo_empty;
    logic [CW-1:0]          fifo_count;

    assign flit_in = {westad, eastad, southad, northad};

    always_comb begin
        cand      = '0;
        gold_cand = '0;
        for (int i = 0; i < 4; i++) begin
            cand[i]      = !is_blank(flit_in[i]) &&
                           (flit_in[i][DEST_HI:DEST_LO] == localad);
            gold_cand[i] = cand[i] && flit_in[i][GOLDEN_BIT];
        end
        // Golden candidates pre-empt the fixed-order choice.
        pool = (|gold_cand) ? gold_cand : cand;

        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pool[i]) begin
                win_idx = 2'(i);
            end
        end
        win_valid = |pool;
        do_eject  = win_valid && !fifo_full;
        push_data = flit_in[win_idx];

        for (int i = 0; i < 4; i++) begin
            out_d[i] = (do_eject && (win_idx == 2'(i))) ? BLANK_FLIT : flit_in[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= {4{BLANK_FLIT}};
        end else begin
            out_q <= out_d;
        end
    end

    assign nad = out_q[0];
    assign sad = out_q[1];
    assign ead = out_q[2];
    assign wad = out_q[3];

    eject_fifo #(
        .WIDTH     (FLIT_W),
        .DEPTH     (FIFO_DEPTH),
        .EMPTY_VAL (BLANK_FLIT)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_eject),
        .din   (push_data),
        .full  (fifo_full),
        .pop   (ej_ready),
        .dout  (ejd),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ej_valid = !fifo_empty;

`ifdef EJECTOR_STATS_EN
    logic [15:0] ej_count_q, ej_count_d;
    logic [15:0] ej_block_q, ej_block_d;

    always_comb begin
        ej_count_d = ej_count_q;
        ej_block_d = ej_block_q;
        if (do_eject && (ej_count_q != 16'hFFFF)) begin
            ej_count_d = ej_count_q + 16'd1;
        end
        if (win_valid && fifo_full && (ej_block_q != 16'hFFFF)) begin
            ej_block_d = ej_block_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ej_count_q <= '0;
            ej_block_q <= '0;
        end else begin
            ej_count_q <= ej_count_d;
            ej_block_q <= ej_block_d;
        end
    end

    assign ej_count_o = ej_count_q;
    assign ej_block_o = ej_block_q;
`else
    logic unused_count;
    assign unused_count = ^fifo_count;
`endif

endmodule

// File: tb/tb_ejector.sv
// tb/tb_ejector.sv - directed self-checking bench for ejector
module tb_ejector;

    localparam logic [9:0] BL = 10'b0_111_000000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] northad, southad, eastad, westad;
    logic [5:0] localad;
    logic [9:0] nad, sad, ead, wad, ejd;
    logic       ej_ready, ej_valid;
`ifdef EJECTOR_STATS_EN
    logic [15:0] ej_count_o, ej_block_o;
`endif

    int checks   = 0;
    int failures = 0;

    ejector #(.FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .northad  (northad),
        .southad  (southad),
        .eastad   (eastad),
        .westad   (westad),
        .localad  (localad),
        .nad      (nad),
        .sad      (sad),
        .ead      (ead),
        .wad      (wad),
        .ejd      (ejd),
        .ej_ready (ej_ready),
        .ej_valid (ej_valid)
`ifdef EJECTOR_STATS_EN
        ,
        .ej_count_o (ej_count_o),
        .ej_block_o (ej_block_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [9:0] n, input logic [9:0] s,
                         input logic [9:0] e, input logic [9:0] w, input logic rdy);
        northad  = n;
        southad  = s;
        eastad   = e;
        westad   = w;
        ej_ready = rdy;
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [9:0] n, input logic [9:0] s,
                              input logic [9:0] e, input logic [9:0] w,
                              input logic v, input logic [9:0] d);
        check({tag, ".nad"}, 16'(nad), 16'(n));
        check({tag, ".sad"}, 16'(sad), 16'(s));
        check({tag, ".ead"}, 16'(ead), 16'(e));
        check({tag, ".wad"}, 16'(wad), 16'(w));
        check({tag, ".ej_valid"}, 16'(ej_valid), 16'(v));
        check({tag, ".ejd"}, 16'(ejd), 16'(d));
    endtask

    initial begin
        localad = 6'o44;
        drive(BL, BL, BL, BL, 1'b0);
        rst = 1'b1;
        #2;
        check_outs("reset", BL, BL, BL, BL, 1'b0, BL);
`ifdef EJECTOR_STATS_EN
        check("reset.count", ej_count_o, 16'd0);
        check("reset.block", ej_block_o, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();

        // Single ejection from north.
        drive(10'b0_100_100100, BL, BL, BL, 1'b0);
        step();
        check_outs("single", BL, BL, BL, BL, 1'b1, 10'b0_100_100100);
        drive(BL, BL, BL, BL, 1'b1);
        step();
        check_outs("single_pop", BL, BL, BL, BL, 1'b0, BL);

        // Golden west beats non-golden north.
        drive(10'b0_100_100100, BL, BL, 10'b1_100_100100, 1'b0);
        step();
        check_outs("golden", 10'b0_100_100100, BL, BL, BL, 1'b1, 10'b1_100_100100);
        drive(BL, BL, BL, BL, 1'b1);
        step();
        check("golden_pop.ej_valid", 16'(ej_valid), 16'd0);

        // Fixed-order tie, one ejection per cycle with continuous pop.
        drive(10'b0_000_100100, 10'b0_001_100100, 10'b0_010_100100, 10'b0_011_100100, 1'b1);
        step();
        check_outs("tie1", BL, 10'b0_001_100100, 10'b0_010_100100, 10'b0_011_100100,
                   1'b1, 10'b0_000_100100);
        step();
        check_outs("tie2", BL, 10'b0_001_100100, 10'b0_010_100100, 10'b0_011_100100,
                   1'b1, 10'b0_000_100100);
        drive(BL, BL, BL, BL, 1'b1);
        step();
        check("tie_drain.ej_valid", 16'(ej_valid), 16'd0);

        // Fill the FIFO with ej_ready low, then a fifth candidate is refused.
        drive(10'b0_000_100100, BL, BL, BL, 1'b0);
        step();
        drive(10'b0_001_100100, BL, BL, BL, 1'b0);
        step();
        drive(10'b0_010_100100, BL, BL, BL, 1'b0);
        step();
        drive(10'b0_011_100100, BL, BL, BL, 1'b0);
        step();
        check_outs("fill4", BL, BL, BL, BL, 1'b1, 10'b0_000_100100);
        drive(10'b0_100_100100, BL, BL, BL, 1'b0);
        step();
        check_outs("full5", 10'b0_100_100100, BL, BL, BL, 1'b1, 10'b0_000_100100);
`ifdef EJECTOR_STATS_EN
        check("full5.count", ej_count_o, 16'd8);
        check("full5.block", ej_block_o, 16'd1);
`endif

        // Full with simultaneous pop: pop happens, candidate passes through.
        drive(10'b1_101_100100, BL, BL, BL, 1'b1);
        step();
        check_outs("fullpop", 10'b1_101_100100, BL, BL, BL, 1'b1, 10'b0_001_100100);
        drive(10'b1_101_100100, BL, BL, BL, 1'b0);
        step();
        check_outs("fullpop_next", BL, BL, BL, BL, 1'b1, 10'b0_001_100100);
`ifdef EJECTOR_STATS_EN
        check("fullpop.count", ej_count_o, 16'd9);
        check("fullpop.block", ej_block_o, 16'd2);
`endif

        // Drain to two entries, put a flit in flight, then reset mid-cycle.
        drive(BL, BL, BL, BL, 1'b1);
        step();
        check("drain1.ejd", 16'(ejd), 16'(10'b0_010_100100));
        step();
        check("drain2.ejd", 16'(ejd), 16'(10'b0_011_100100));
        drive(BL, 10'b0_000_000001, BL, BL, 1'b0);
        step();
        check_outs("inflight", BL, 10'b0_000_000001, BL, BL, 1'b1, 10'b0_011_100100);
        #2;
        rst = 1'b1;
        #1;
        check_outs("midreset", BL, BL, BL, BL, 1'b0, BL);
`ifdef EJECTOR_STATS_EN
        check("midreset.count", ej_count_o, 16'd0);
        check("midreset.block", ej_block_o, 16'd0);
`endif
        drive(BL, BL, 10'b0_000_100100, BL, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_outs("post_reset", BL, BL, BL, BL, 1'b1, 10'b0_000_100100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
